uart2axi_burst_engine: RTL

- Parameterised successor to the single-word UART-to-AXI bridge state machine.
- Consumes a byte stream from a UART receiver and decodes framed read/write commands.
- Each command carries a beat count of 1..MAX_BURST; the engine issues that many sequential AXI4-Lite single-beat transactions at incrementing addresses.
- Read data and a per-command status byte (carrying the AXI error response) are returned over a byte stream to a UART transmitter.

---
 rtl/uart2axi_burst_engine.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart2axi_burst_engine.sv
// uart2axi_burst_engine
// Decodes framed read/write commands arriving as a UART byte stream and runs
// them as a burst of sequential single-beat AXI4-Lite transactions.
// Read data (MSB first) and a final status byte go back out on the tx stream.
//
// Frame: opcode (0x57 write / 0x52 read), N-1, AB address bytes, then for
// writes N*DB data bytes. All multi-byte fields are big-endian.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   rx_data/rx_valid     incoming byte strobe from the UART receiver
//   rx_drop              one-cycle pulse when a byte arrives while not accepting
//   tx_data/valid/ready  outgoing byte stream to the UART transmitter
//   busy                 engine is not idle
//   m_axi_*              AXI4-Lite master (AW/W/B, AR/R channels)
module uart2axi_burst_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int RX_TIMEOUT = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_drop,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int AB = ADDR_WIDTH / 8;
    localparam int DB = DATA_WIDTH / 8;
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(RX_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_GET_CNT     = 4'd1;
    localparam logic [3:0] S_GET_ADDR    = 4'd2;
    localparam logic [3:0] S_GET_WDATA   = 4'd3;
    localparam logic [3:0] S_AXI_AW_W    = 4'd4;
    localparam logic [3:0] S_AXI_B       = 4'd5;
    localparam logic [3:0] S_AXI_AR      = 4'd6;
    localparam logic [3:0] S_AXI_R       = 4'd7;
    localparam logic [3:0] S_SEND_RDATA  = 4'd8;
    localparam logic [3:0] S_SEND_STATUS = 4'd9;

    logic [3:0]                           state_q, state_d;
    logic                                 wr_q, wr_d;
    logic [CW-1:0]                        cnt_q, cnt_d;    // beats - 1
    logic [CW-1:0]                        beat_q, beat_d;
    logic [3:0]                           bcnt_q, bcnt_d;  // byte index within a field
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [MAX_BURST-1:0][DATA_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [DATA_WIDTH-1:0]                rsh_q, rsh_d;    // read data, shifted out MSB first
    logic [TW-1:0]                        tmo_q, tmo_d;
    logic awv_q, awv_d, wv_q, wv_d, brdy_q, brdy_d, arv_q, arv_d, rrdy_q, rrdy_d;
    logic txv_q, txv_d, drop_q, drop_d;
    logic [7:0] txd_q, txd_d;

    logic in_get, accepting, last_beat;
    assign in_get    = (state_q == S_GET_CNT) || (state_q == S_GET_ADDR) || (state_q == S_GET_WDATA);
    assign accepting = in_get || (state_q == S_IDLE);
    assign last_beat = (beat_q == cnt_q);

    always_comb begin
        state_d = state_q; wr_d = wr_q; cnt_d = cnt_q; beat_d = beat_q; bcnt_d = bcnt_q;
        addr_d = addr_q; wbuf_d = wbuf_q; rsh_d = rsh_q; tmo_d = tmo_q;
        awv_d = awv_q; wv_d = wv_q; brdy_d = brdy_q; arv_d = arv_q; rrdy_d = rrdy_q;
        txv_d = txv_q; txd_d = txd_q;
        drop_d = rx_valid && !accepting;

        case (state_q)
            S_IDLE: if (rx_valid) begin
                tmo_d = '0;
                if (rx_data == 8'h57 || rx_data == 8'h52) begin
                    wr_d    = (rx_data == 8'h57);
                    state_d = S_GET_CNT;
                end else begin
                    txv_d   = 1'b1;
                    txd_d   = 8'hFE;
                    state_d = S_SEND_STATUS;
                end
            end
            S_GET_CNT: if (rx_valid) begin
                cnt_d   = (int'(rx_data) >= MAX_BURST) ? CW'(MAX_BURST - 1) : CW'(rx_data);
                bcnt_d  = '0;
                state_d = S_GET_ADDR;
            end
            S_GET_ADDR: if (rx_valid) begin
                addr_d = ADDR_WIDTH'({addr_q, rx_data});
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == 4'(AB - 1)) begin
                    bcnt_d = '0;
                    beat_d = '0;
                    if (wr_q) begin
                        state_d = S_GET_WDATA;
                    end else begin
                        arv_d   = 1'b1;
                        state_d = S_AXI_AR;
                    end
                end
            end
            S_GET_WDATA: if (rx_valid) begin
                wbuf_d[beat_q] = DATA_WIDTH'({wbuf_q[beat_q], rx_data});
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == 4'(DB - 1)) begin
                    bcnt_d = '0;
                    if (last_beat) begin
                        beat_d  = '0;
                        awv_d   = 1'b1;
                        wv_d    = 1'b1;
                        state_d = S_AXI_AW_W;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_AXI_AW_W: begin
                // AW and W complete independently; a low valid here means that
                // channel has already handshaken for this beat.
                if (m_axi_awready) awv_d = 1'b0;
                if (m_axi_wready)  wv_d  = 1'b0;
                if ((!awv_q || m_axi_awready) && (!wv_q || m_axi_wready)) begin
                    brdy_d  = 1'b1;
                    state_d = S_AXI_B;
                end
            end
            S_AXI_B: if (m_axi_bvalid) begin
                brdy_d = 1'b0;
                if (m_axi_bresp != 2'b00 || last_beat) begin
                    txv_d   = 1'b1;
                    txd_d   = {6'b0, m_axi_bresp};
                    state_d = S_SEND_STATUS;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(DB);
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = S_AXI_AW_W;
                end
            end
            S_AXI_AR: if (m_axi_arready) begin
                arv_d   = 1'b0;
                rrdy_d  = 1'b1;
                state_d = S_AXI_R;
            end
            S_AXI_R: if (m_axi_rvalid) begin
                rrdy_d = 1'b0;
                txv_d  = 1'b1;
                if (m_axi_rresp != 2'b00) begin
                    txd_d   = {6'b0, m_axi_rresp};
                    state_d = S_SEND_STATUS;
                end else begin
                    txd_d   = m_axi_rdata[DATA_WIDTH-1 -: 8];
                    rsh_d   = m_axi_rdata << 8;
                    bcnt_d  = '0;
                    state_d = S_SEND_RDATA;
                end
            end
            S_SEND_RDATA: if (tx_ready) begin
                bcnt_d = bcnt_q + 4'd1;
                txd_d  = rsh_q[DATA_WIDTH-1 -: 8];
                rsh_d  = rsh_q << 8;
                if (bcnt_q == 4'(DB - 1)) begin
                    bcnt_d = '0;
                    if (last_beat) begin
                        txd_d   = 8'h00;
                        state_d = S_SEND_STATUS;
                    end else begin
                        txv_d   = 1'b0;
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(DB);
                        arv_d   = 1'b1;
                        state_d = S_AXI_AR;
                    end
                end
            end
            S_SEND_STATUS: if (tx_ready) begin
                txv_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte timeout: a stalled partial frame is dropped without status.
        if (in_get && !rx_valid) begin
            if (tmo_q == TW'(RX_TIMEOUT - 1)) begin
                tmo_d   = '0;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (in_get) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; wr_q <= 1'b0; cnt_q <= '0; beat_q <= '0; bcnt_q <= '0;
            addr_q <= '0; wbuf_q <= '0; rsh_q <= '0; tmo_q <= '0;
            awv_q <= 1'b0; wv_q <= 1'b0; brdy_q <= 1'b0; arv_q <= 1'b0; rrdy_q <= 1'b0;
            txv_q <= 1'b0; txd_q <= '0; drop_q <= 1'b0;
        end else begin
            state_q <= state_d; wr_q <= wr_d; cnt_q <= cnt_d; beat_q <= beat_d; bcnt_q <= bcnt_d;
            addr_q <= addr_d; wbuf_q <= wbuf_d; rsh_q <= rsh_d; tmo_q <= tmo_d;
            awv_q <= awv_d; wv_q <= wv_d; brdy_q <= brdy_d; arv_q <= arv_d; rrdy_q <= rrdy_d;
            txv_q <= txv_d; txd_q <= txd_d; drop_q <= drop_d;
        end
    end

    assign rx_drop       = drop_q;
    assign tx_data       = txd_q;
    assign tx_valid      = txv_q;
    assign busy          = (state_q != S_IDLE);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awv_q;
    assign m_axi_wdata   = wbuf_q[beat_q];
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wv_q;
    assign m_axi_bready  = brdy_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arv_q;
    assign m_axi_rready  = rrdy_q;
endmodule
